// File: rtl/iterative_mul_div.sv
// Radix-2 iterative multiply/divide: WIDTH+1 cycles after accept, 1 cycle for div-by-zero/overflow.
// Holds result in DONE until outReady; inReady only while IDLE; kill aborts CALC/FIX.
module iterative_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             kill,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               byp_dz_q, byp_dz_d;
    logic               byp_ov_q, byp_ov_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;

    // Operand decode at acceptance
    logic             a_signed, b_signed;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] byp_res;

    always_comb begin
        a_signed = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
        b_signed = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        sa       = a_signed & opA[WIDTH-1];
        sb       = b_signed & opB[WIDTH-1];
        mag_a    = sa ? -opA : opA;
        mag_b    = sb ? -opB : opB;
        div_zero = op[2] && (opB == '0);
        div_ovf  = op[2] && !op[0] && (opA == MIN_VAL) && (opB == '1);
        if (div_zero) begin
            byp_res = op[1] ? opA : '1;
        end else begin
            byp_res = op[1] ? '0 : MIN_VAL;
        end
    end

    // One iteration step: acc holds {hi, lo}; mul shifts right, div shifts left
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    end

    // Sign fix-up and result selection
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:                  fix_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:          fix_res = quo_fix;
            default:                 fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        byp_dz_d = byp_dz_q;
        byp_ov_d = byp_ov_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        res_d    = res_q;
        flags_d  = flags_q;
        inReady  = (state_q == IDLE);
        outValid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    op_d     = op;
                    sign_a_d = sa;
                    sign_b_d = sb;
                    byp_dz_d = div_zero;
                    byp_ov_d = div_ovf && !div_zero;
                    cnt_d    = '0;
                    state_d  = CALC;
                    if (div_zero || div_ovf) begin
                        acc_d = {{WIDTH{1'b0}}, byp_res};
                    end else begin
                        opnd_d = op[2] ? mag_b : mag_a;
                        acc_d  = {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (byp_dz_q || byp_ov_q) begin
                    // Special-case division: result was parked in acc at acceptance
                    res_d   = acc_q[WIDTH-1:0];
                    flags_d = {byp_dz_q, byp_ov_q, acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0)};
                    state_d = DONE;
                end else begin
                    acc_d = op_q[2] ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                                    : {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    res_d   = fix_res;
                    flags_d = {2'b00, fix_res[WIDTH-1], (fix_res == '0)};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            byp_dz_q <= 1'b0;
            byp_ov_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            byp_dz_q <= byp_dz_d;
            byp_ov_q <= byp_ov_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
        end
    end

    assign result = res_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_iterative_mul_div.sv
// Directed and randomized checks of iterative_mul_div against an arithmetic reference model.
module tb_iterative_mul_div;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [2:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         kill;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks   = 0;
    int failures = 0;

    iterative_mul_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .kill     (kill),
        .outValid (outValid),
        .outReady (outReady),
        .result   (result),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the architectural operation definitions
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            dz;
        logic            ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        ov = 1'b0;
        p  = '0;
        case (o)
            3'd0: begin p = ua * ub;           r = p[31:0];  end
            3'd1: begin p = sa * sb;           r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub;           r = p[63:32]; end
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    r  = o[1] ? a : 32'hFFFF_FFFF;
                end else if (!o[0] && a == MINV && b == 32'hFFFF_FFFF) begin
                    ov = 1'b1;
                    r  = o[1] ? 32'h0 : MINV;
                end else begin
                    case (o)
                        3'd4:    p = sa / sb;
                        3'd5:    p = ua / ub;
                        3'd6:    p = sa % sb;
                        default: p = ua % ub;
                    endcase
                    r = p[31:0];
                end
            end
        endcase
        f = {dz, ov, r[31], (r == 0)};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic kill_acc,
                          input logic hold);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           lat;
        model(o, a, b, er, ef);
        @(negedge clk);
        check({tag, "/inReady"}, inReady, 1);
        inValid = 1'b1;
        op      = o;
        opA     = a;
        opB     = b;
        kill    = kill_acc;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        kill    = 1'b0;
        op      = 3'($urandom);
        opA     = $urandom;
        opB     = $urandom;
        lat     = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!outValid && lat < 60);
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/result"}, result, er);
        check({tag, "/flags"}, flags, ef);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                kill = 1'b1;
                @(posedge clk);
                #1;
                check({tag, "/hold_valid"}, outValid, 1);
                check({tag, "/hold_inReady"}, inReady, 0);
                check({tag, "/hold_result"}, result, er);
                check({tag, "/hold_flags"}, flags, ef);
            end
            kill = 1'b0;
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check({tag, "/release_valid"}, outValid, 0);
        check({tag, "/release_inReady"}, inReady, 1);
    endtask

    task automatic abort_test(input string tag, input logic use_rst);
        int seen;
        @(negedge clk);
        inValid = 1'b1;
        op      = 3'd0;
        opA     = $urandom;
        opB     = $urandom;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else kill = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        kill = 1'b0;
        check({tag, "/inReady"}, inReady, 1);
        check({tag, "/valid"}, outValid, 0);
        if (use_rst) begin
            check({tag, "/result"}, result, 0);
            check({tag, "/flags"}, flags, 0);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        check({tag, "/no_valid"}, seen, 0);
        run_op({tag, "/mul3x4"}, 3'd0, 32'd3, 32'd4, 33, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;
        int           el;

        rst      = 1'b1;
        inValid  = 1'b0;
        op       = '0;
        opA      = '0;
        opB      = '0;
        kill     = 1'b0;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset/inReady", inReady, 1);
        check("reset/valid", outValid, 0);
        check("reset/result", result, 0);
        check("reset/flags", flags, 0);

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 33, 1'b0, 1'b1);
        run_op("mulh_min", 3'd1, MINV, MINV, 33, 1'b0, 1'b0);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 33, 1'b0, 1'b0);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, 1'b0);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 33, 1'b0, 1'b0);
        run_op("divu", 3'd5, 32'd100, 32'd7, 33, 1'b1, 1'b0);
        run_op("remu", 3'd7, 32'd100, 32'd7, 33, 1'b0, 1'b0);
        run_op("divu_zero", 3'd5, 32'd5, 32'd0, 1, 1'b0, 1'b0);
        run_op("rem_zero", 3'd6, 32'd5, 32'd0, 1, 1'b0, 1'b1);
        run_op("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        run_op("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);

        abort_test("kill", 1'b0);
        abort_test("rst", 1'b1);

        for (int i = 0; i < 30; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = MINV; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 3));
            el = (ro[2] && (rb == 0 || (!ro[0] && ra == MINV && rb == 32'hFFFF_FFFF))) ? 1 : 33;
            run_op("random", ro, ra, rb, el, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
